acc_sequencer: RTL and testbench

//  Micro-sequencer for the 4-bit accumulator datapath (Abus -> SelB mux -> ALU add -> AC -> outbus).

---
 rtl/acc_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_acc_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// -----------------------------------------------------------------------------
// acc_sequencer
//   Micro-sequencer for the accumulator datapath
//   (Abus -> SelB mux -> ALU add -> AC -> outbus).
//   It accepts one command per valid/ready handshake and plays it out on the
//   datapath controls as a timed sequence: SETUP (controls stable, no load),
//   EXEC (one-cycle LoadAc), then CAPTURE/DONE to return the final AC value,
//   a sticky carry flag and a one-cycle done pulse.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake; ready is high only in IDLE
//   cmd_op            00 CLR, 01 LOAD, 10 ADD, 11 REPEAT_ADD
//   cmd_operand       value placed on Abus
//   cmd_count         number of additions for REPEAT_ADD
//   Abus/SelB/AddAlu/LoadAc   registered datapath controls
//   outbus            current AC value from the datapath
//   busy              high in every state except IDLE
//   done              one-cycle pulse; result/result_carry valid with it
//   result            AC value captured at the end of a command (held)
//   result_carry      1 if any addition of the command wrapped (held)
// -----------------------------------------------------------------------------
module acc_sequencer #(
    parameter int WIDTH         = 4,
    parameter int CNT_W         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] Abus,
    output logic             SelB,
    output logic             AddAlu,
    output logic             LoadAc,
    input  logic [WIDTH-1:0] outbus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_carry
);

    // Settle counter counts down from SETTLE_CYCLES-1 to 0 inside SETUP.
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        OP_CLR    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_ADD    = 2'b10,
        OP_REPEAT = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Carry-out of an unsigned WIDTH-bit addition.
    function automatic logic add_carry(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH];
    endfunction

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               carry_acc_q, carry_acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               result_carry_q, result_carry_d;

    logic [WIDTH-1:0]   abus_q, abus_d;
    logic               selb_q, selb_d;
    logic               add_alu_q, add_alu_d;
    logic               load_ac_q, load_ac_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cmd_ready_q, cmd_ready_d;

    // Next-state and command-register update.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        operand_d      = operand_q;
        cnt_d          = cnt_q;
        settle_d       = settle_q;
        carry_acc_d    = carry_acc_q;
        result_d       = result_q;
        result_carry_d = result_carry_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = op_e'(cmd_op);
                    operand_d   = cmd_operand;
                    cnt_d       = cmd_count;
                    carry_acc_d = 1'b0;
                    settle_d    = SETTLE_LOAD;
                    // A zero-length repeat has nothing to execute.
                    if ((op_e'(cmd_op) == OP_REPEAT) && (cmd_count == {CNT_W{1'b0}})) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (settle_q == {SET_W{1'b0}}) begin
                    state_d = ST_EXEC;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end

            ST_EXEC: begin
                // outbus still holds the pre-load AC here, so this is the
                // carry of the addition being committed by LoadAc.
                if ((op_q == OP_ADD) || (op_q == OP_REPEAT)) begin
                    carry_acc_d = carry_acc_q | add_carry(outbus, operand_q);
                end else begin
                    carry_acc_d = carry_acc_q;
                end
                if (op_q == OP_REPEAT) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q != CNT_W'(1)) begin
                        state_d  = ST_SETUP;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                result_d       = outbus;
                result_carry_d = carry_acc_q;
                state_d        = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so every output is a flop.
    always_comb begin
        abus_d      = {WIDTH{1'b0}};
        selb_d      = 1'b0;
        add_alu_d   = 1'b0;
        load_ac_d   = (state_d == ST_EXEC);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        cmd_ready_d = (state_d == ST_IDLE);

        if ((state_d == ST_SETUP) || (state_d == ST_EXEC)) begin
            case (op_d)
                OP_CLR: begin
                    abus_d = {WIDTH{1'b0}};
                end
                OP_LOAD: begin
                    abus_d = operand_d;
                end
                OP_ADD, OP_REPEAT: begin
                    abus_d    = operand_d;
                    selb_d    = 1'b1;
                    add_alu_d = 1'b1;
                end
                default: begin
                    abus_d = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            abus_d = {WIDTH{1'b0}};
        end
    end

    // State, command and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_CLR;
            operand_q      <= {WIDTH{1'b0}};
            cnt_q          <= {CNT_W{1'b0}};
            settle_q       <= {SET_W{1'b0}};
            carry_acc_q    <= 1'b0;
            result_q       <= {WIDTH{1'b0}};
            result_carry_q <= 1'b0;
            abus_q         <= {WIDTH{1'b0}};
            selb_q         <= 1'b0;
            add_alu_q      <= 1'b0;
            load_ac_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cmd_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            operand_q      <= operand_d;
            cnt_q          <= cnt_d;
            settle_q       <= settle_d;
            carry_acc_q    <= carry_acc_d;
            result_q       <= result_d;
            result_carry_q <= result_carry_d;
            abus_q         <= abus_d;
            selb_q         <= selb_d;
            add_alu_q      <= add_alu_d;
            load_ac_q      <= load_ac_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cmd_ready_q    <= cmd_ready_d;
        end
    end

    assign Abus         = abus_q;
    assign SelB         = selb_q;
    assign AddAlu       = add_alu_q;
    assign LoadAc       = load_ac_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cmd_ready    = cmd_ready_q;
    assign result       = result_q;
    assign result_carry = result_carry_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acc_sequencer
//   Drives commands into acc_sequencer, models the accumulator datapath it
//   controls, and checks every done against a scoreboard of expectations
//   computed from an independent reference AC when each command is issued.
// -----------------------------------------------------------------------------
module tb_acc_sequencer;

    localparam int W = 4;
    localparam int C = 3;
    localparam int S = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_operand = 4'h0;
    logic [C-1:0] cmd_count = 3'd0;
    logic [W-1:0] Abus;
    logic         SelB, AddAlu, LoadAc;
    logic [W-1:0] outbus;
    logic         busy, done;
    logic [W-1:0] result;
    logic         result_carry;

    acc_sequencer #(.WIDTH(W), .CNT_W(C), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_count(cmd_count),
        .Abus(Abus), .SelB(SelB), .AddAlu(AddAlu), .LoadAc(LoadAc),
        .outbus(outbus), .busy(busy), .done(done),
        .result(result), .result_carry(result_carry)
    );

    always #5 clk = ~clk;

    // Datapath model: AC register fed by the SelB mux.
    logic [W-1:0] ac_dp = 4'h0;
    assign outbus = ac_dp;
    always @(posedge clk) begin
        if (LoadAc) begin
            ac_dp <= SelB ? (AddAlu ? ac_dp + Abus : Abus) : Abus;
        end
    end

    // Cycle and handshake bookkeeping.
    int cyc = 0;
    int hs_cyc = 0;
    int hs_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && cmd_valid && cmd_ready) begin
            hs_cyc <= cyc + 1;
            hs_cnt <= hs_cnt + 1;
        end
    end

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        int           lat;
        int           loads;
        logic [W-1:0] abus;
        logic         selb;
        logic         addalu;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] ref_ac = 4'h0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           done_cnt = 0;
    int           load_cnt = 0;
    logic [W-1:0] last_res = 4'h0;
    logic         last_cy = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: expected outcome of a command given the current AC.
    task automatic build_exp(input logic [1:0] op, input logic [W-1:0] opd,
                             input logic [C-1:0] cnt, output exp_t e);
        logic [W:0] s;
        e.cy = 1'b0; e.abus = 4'h0; e.selb = 1'b0; e.addalu = 1'b0;
        e.loads = 1; e.lat = S + 3;
        case (op)
            2'b00: ref_ac = 4'h0;
            2'b01: begin ref_ac = opd; e.abus = opd; end
            2'b10: begin
                e.abus = opd; e.selb = 1'b1; e.addalu = 1'b1;
                s = {1'b0, ref_ac} + {1'b0, opd};
                e.cy = s[W]; ref_ac = s[W-1:0];
            end
            default: begin
                e.abus = opd; e.selb = 1'b1; e.addalu = 1'b1;
                e.loads = int'(cnt);
                e.lat = (cnt == 3'd0) ? 2 : int'(cnt) * (S + 1) + 2;
                for (int i = 0; i < int'(cnt); i++) begin
                    s = {1'b0, ref_ac} + {1'b0, opd};
                    e.cy = e.cy | s[W]; ref_ac = s[W-1:0];
                end
            end
        endcase
        e.res = ref_ac;
    endtask

    // Issue a command and wait for its done; hold keeps cmd_valid high
    // (with scrambled payload) for the whole busy period.
    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] opd,
                            input logic [C-1:0] cnt, input bit hold);
        exp_t e;
        int   t;
        build_exp(op, opd, cnt, e);
        sb_q.push_back(e);
        cmd_valid = 1'b1; cmd_op = op; cmd_operand = opd; cmd_count = cnt;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        if (!cmd_ready) check_eq("handshake_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            cmd_op = 2'b11; cmd_operand = ~opd; cmd_count = 3'd5;
        end else begin
            cmd_valid = 1'b0;
        end
        t = 0;
        while (!done && t < 100) begin @(negedge clk); t++; end
        if (!done) check_eq("done_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    // Output monitor and scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_eq("ready_vs_busy", int'(cmd_ready), int'(!busy));
                if (LoadAc) begin
                    load_cnt++;
                    if (sb_q.size() > 0) begin
                        check_eq("ctl_abus", int'(Abus), int'(sb_q[0].abus));
                        check_eq("ctl_selb", int'(SelB), int'(sb_q[0].selb));
                        check_eq("ctl_addalu", int'(AddAlu), int'(sb_q[0].addalu));
                    end else begin
                        check_eq("unexpected_load", 1, 0);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check_eq("result", int'(result), int'(e.res));
                        check_eq("result_carry", int'(result_carry), int'(e.cy));
                        check_eq("latency", cyc - hs_cyc + 1, e.lat);
                        check_eq("load_pulses", load_cnt, e.loads);
                    end else begin
                        check_eq("unexpected_done", 1, 0);
                    end
                    last_res = result; last_cy = result_carry;
                    load_cnt = 0;
                end else begin
                    check_eq("result_hold", int'(result), int'(last_res));
                    check_eq("carry_hold", int'(result_carry), int'(last_cy));
                end
            end
        end
    end

    initial begin
        int hs0, dn0, t;
        exp_t e;
        logic [W-1:0] saved_ac;

        // Reset for two cycles.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_abus", int'(Abus), 0);
        check_eq("rst_selb", int'(SelB), 0);
        check_eq("rst_addalu", int'(AddAlu), 0);
        check_eq("rst_loadac", int'(LoadAc), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_result", int'(result), 0);
        check_eq("rst_carry", int'(result_carry), 0);
        check_eq("rst_ready", int'(cmd_ready), 1);
        @(negedge clk);

        send_cmd(2'b01, 4'hF, 3'd0, 1'b0);   // LOAD F
        send_cmd(2'b10, 4'h6, 3'd0, 1'b0);   // ADD 6 -> 5, carry
        send_cmd(2'b01, 4'h1, 3'd0, 1'b0);   // LOAD 1
        send_cmd(2'b11, 4'h2, 3'd3, 1'b0);   // REPEAT 2 x3 -> 7
        send_cmd(2'b11, 4'h9, 3'd0, 1'b0);   // REPEAT x0 -> 7
        send_cmd(2'b01, 4'hE, 3'd0, 1'b0);   // LOAD E
        send_cmd(2'b11, 4'h3, 3'd7, 1'b0);   // REPEAT 3 x7 -> 3, carry
        send_cmd(2'b00, 4'hA, 3'd4, 1'b0);   // CLR
        for (int i = 0; i < 12; i++) begin
            send_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 1'b0);
        end

        // Reset during EXEC of an ADD: the command must be discarded.
        saved_ac = ref_ac;
        build_exp(2'b10, 4'h4, 3'd0, e);
        sb_q.push_back(e);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_operand = 4'h4; cmd_count = 3'd0;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!LoadAc && t < 20) begin @(negedge clk); t++; end
        check_eq("exec_reached", int'(LoadAc), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_loadac", int'(LoadAc), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_selb", int'(SelB), 0);
        ref_ac = saved_ac;
        sb_q.delete();
        load_cnt = 0; last_res = 4'h0; last_cy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", int'(cmd_ready), 1);
        check_eq("post_rst_busy", int'(busy), 0);
        check_eq("ac_untouched", int'(outbus), int'(saved_ac));

        // cmd_valid held through busy: exactly one handshake and one done.
        @(negedge clk);
        hs0 = hs_cnt; dn0 = done_cnt;
        send_cmd(2'b01, 4'h9, 3'd0, 1'b1);
        repeat (6) @(negedge clk);
        check_eq("hold_handshakes", hs_cnt - hs0, 1);
        check_eq("hold_dones", done_cnt - dn0, 1);
        send_cmd(2'b10, 4'h9, 3'd0, 1'b0);   // ADD 9 -> 2, carry
        repeat (4) @(negedge clk);
        check_eq("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
